// File: rtl/instr_encoder.sv
// Field-set to RV32 instruction encoder feeding a 4-entry output FIFO with a running byte address.
// Optional IMM_RANGE_CHECK_EN drops and flags requests whose immediate does not fit its format.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [2:0]  count,
  output logic        err,
  input  logic        err_clr
);

  localparam int unsigned Depth = 4;

  localparam logic [2:0] FmtR      = 3'd0;
  localparam logic [2:0] FmtI      = 3'd1;
  localparam logic [2:0] FmtLoad   = 3'd2;
  localparam logic [2:0] FmtStore  = 3'd3;
  localparam logic [2:0] FmtBranch = 3'd4;

  logic [31:0] mem_q [Depth];
  logic [1:0]  wptr_q, rptr_q;
  logic [2:0]  count_q, count_d;
  logic [31:0] addr_q;
  logic        err_q, err_d;

  logic [31:0] enc;
  logic        legal;
  logic        imm12_ok, imm13_ok;
  logic        accept, push, pop;

  // Bits above the widest immediate field only matter to the range check.
  logic unused_imm;
  assign unused_imm = ^in_imm[63:13];

`ifdef IMM_RANGE_CHECK_EN
  logic signed [63:0] imm_s;
  assign imm_s    = $signed(in_imm);
  assign imm12_ok = (imm_s >= -64'sd2048) && (imm_s <= 64'sd2047);
  assign imm13_ok = (imm_s >= -64'sd4096) && (imm_s <= 64'sd4094) && !in_imm[0];
`else
  assign imm12_ok = 1'b1;
  assign imm13_ok = 1'b1;
`endif

  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (in_fmt)
      FmtR: begin
        enc   = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
        legal = 1'b1;
      end
      FmtI: begin
        enc   = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        legal = imm12_ok;
      end
      FmtLoad: begin
        enc   = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        legal = imm12_ok;
      end
      FmtStore: begin
        enc   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
        legal = imm12_ok;
      end
      FmtBranch: begin
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11],
                 7'b1100011};
        legal = imm13_ok;
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign in_ready  = (count_q != 3'(Depth));
  assign out_valid = (count_q != 3'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // A fresh error outranks a same-cycle clear.
  always_comb begin
    err_d = err_q;
    if (accept && !legal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= enc;
        wptr_q        <= wptr_q + 2'd1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 2'd1;
        addr_q <= addr_q + 32'd4;
      end
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign out_instr = out_valid ? mem_q[rptr_q] : '0;
  assign out_addr  = addr_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, corner sequences, and a randomized run
// against a queue-based model that also decodes the instruction to confirm the immediate.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [63:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [2:0]  count;
  logic        err;
  logic        err_clr = 1'b0;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .count     (count),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder built from field positions with shifts and adds.
  function automatic logic [31:0] model_enc(input logic [2:0] fmt, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [63:0] imm);
    longint unsigned u, r, regs;
    u    = imm;
    regs = (64'(rs1) << 15) + (64'(f3) << 12);
    case (fmt)
      3'd0: r = (64'(f7) << 25) + (64'(rs2) << 20) + regs + (64'(rd) << 7) + 64'h33;
      3'd1: r = ((u & 64'hFFF) << 20) + regs + (64'(rd) << 7) + 64'h13;
      3'd2: r = ((u & 64'hFFF) << 20) + regs + (64'(rd) << 7) + 64'h03;
      3'd3: r = (((u >> 5) & 64'h7F) << 25) + (64'(rs2) << 20) + regs + ((u & 64'h1F) << 7)
                + 64'h23;
      default: r = (((u >> 12) & 1) << 31) + (((u >> 5) & 64'h3F) << 25) + (64'(rs2) << 20)
                   + regs + (((u >> 1) & 64'hF) << 8) + (((u >> 11) & 1) << 7) + 64'h63;
    endcase
    return r[31:0];
  endfunction

  // Immediate recovered from an encoded instruction, as a decoder would.
  function automatic longint model_dec_imm(input logic [31:0] instr, input logic [2:0] fmt);
    longint unsigned w;
    longint v;
    w = 64'(instr);
    if (fmt == 3'd4) begin
      v = longint'((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5)
                   | (((w >> 8) & 15) << 1));
      if (v >= 4096) v = v - 8192;
    end else if (fmt == 3'd3) begin
      v = longint'((((w >> 25) & 127) << 5) | ((w >> 7) & 31));
      if (v >= 2048) v = v - 4096;
    end else begin
      v = longint'((w >> 20) & 4095);
      if (v >= 2048) v = v - 4096;
    end
    return v;
  endfunction

  function automatic bit in_range(input logic [2:0] fmt, input logic [63:0] imm);
    longint s;
    s = imm;
    if (fmt >= 3'd1 && fmt <= 3'd3) return (s >= -2048) && (s <= 2047);
    if (fmt == 3'd4) return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
    return 1'b0;
  endfunction

  function automatic bit model_legal(input logic [2:0] fmt, input logic [63:0] imm);
    if (fmt > 3'd4) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    if (fmt != 3'd0) return in_range(fmt, imm);
`endif
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] imm);
    in_fmt    = fmt;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  // Reset asserted between edges so the checks see the asynchronous response.
  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_addr", 64'(out_addr), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_out_instr", 64'(out_instr), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    longint      imm;
    logic [2:0]  fmt;
    bit          rt;
  } ent_t;

  vec_t vt[5];
  ent_t mq[$];

  initial begin
    vt[0] = '{3'd1, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, -64'sd1, 32'hFFF30293};
    vt[1] = '{3'd3, 5'd0, 5'd2, 5'd3, 3'd3, 7'd0, 64'd8, 32'h00313423};
    vt[2] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -64'sd4, 32'hFE208EE3};
    vt[3] = '{3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 64'hDEAD_BEEF_1234_5678, 32'h403100B3};
    vt[4] = '{3'd2, 5'd10, 5'd11, 5'd0, 3'd2, 7'd0, 64'd100, 32'h0645A503};

    do_reset();

    // Directed vectors, one push then one pop each.
    for (int i = 0; i < 5; i++) begin
      set_req(vt[i].fmt, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].f3, vt[i].f7, vt[i].imm);
      #1;
      chk($sformatf("vec%0d_no_comb_path", i), 64'(out_valid), 0);
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 1);
      chk($sformatf("vec%0d_instr", i), 64'(out_instr), 64'(vt[i].exp));
      chk($sformatf("vec%0d_addr", i), 64'(out_addr), 64'(i * 4));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("vec%0d_drained", i), 64'(count), 0);
    end

    // Fill past capacity, then drain in order.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_req(3'd1, 5'(k + 1), 5'd2, 5'd0, 3'd0, 7'd0, 64'(k));
      chk($sformatf("fill%0d_in_ready", k), 64'(in_ready), (k < 4) ? 1 : 0);
      step();
    end
    in_valid = 1'b0;
    chk("full_count", 64'(count), 4);
    chk("full_in_ready", 64'(in_ready), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_addr", k), 64'(out_addr), 64'(k * 4));
      chk($sformatf("drain%0d_instr", k), 64'(out_instr),
          64'(model_enc(3'd1, 5'(k + 1), 5'd2, 5'd0, 3'd0, 7'd0, 64'(k))));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 64'(count), 0);

    // Push and pop together mid-occupancy.
    set_req(3'd0, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 64'd0);
    step();
    set_req(3'd0, 5'd2, 5'd2, 5'd2, 3'd2, 7'd2, 64'd0);
    step();
    set_req(3'd0, 5'd3, 5'd3, 5'd3, 3'd3, 7'd3, 64'd0);
    out_ready = 1'b1;
    step();
    idle();
    chk("pushpop_count", 64'(count), 2);
    chk("pushpop_head", 64'(out_instr),
        64'(model_enc(3'd0, 5'd2, 5'd2, 5'd2, 3'd2, 7'd2, 64'd0)));
    chk("pushpop_addr", 64'(out_addr), 20);

    // Illegal format, sticky error, clear and clear-vs-new-error priority.
    do_reset();
    set_req(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 64'd0);
    chk("illegal_in_ready", 64'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("illegal_no_write", 64'(count), 0);
    chk("illegal_err", 64'(err), 1);
    step();
    chk("err_sticky", 64'(err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", 64'(err), 0);
    set_req(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 64'd0);
    err_clr = 1'b1;
    step();
    idle();
    chk("err_priority", 64'(err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Out-of-range immediate.
    set_req(3'd1, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 64'd4096);
    step();
    in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    chk("imm4096_dropped", 64'(count), 0);
    chk("imm4096_err", 64'(err), 1);
`else
    chk("imm4096_count", 64'(count), 1);
    chk("imm4096_instr", 64'(out_instr), 64'h00030293);
    chk("imm4096_no_err", 64'(err), 0);
`endif

    // Reset while entries are queued.
    do_reset();
    set_req(3'd0, 5'd9, 5'd9, 5'd9, 3'd0, 7'd0, 64'd0);
    step();
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("premid_addr", 64'(out_addr), 4);
    do_reset();
    set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd7);
    step();
    in_valid = 1'b0;
    chk("postrst_count", 64'(count), 1);
    chk("postrst_addr", 64'(out_addr), 0);

    // Randomized run against the queue model.
    do_reset();
    begin
      logic [31:0] maddr;
      bit          merr;
      maddr = 0;
      merr  = 1'b0;
      mq.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
        int r;
        bit acc, pop;
        chk("rnd_count", 64'(count), 64'(mq.size()));
        chk("rnd_in_ready", 64'(in_ready), (mq.size() < 4) ? 1 : 0);
        chk("rnd_out_valid", 64'(out_valid), (mq.size() != 0) ? 1 : 0);
        chk("rnd_out_addr", 64'(out_addr), 64'(maddr));
        chk("rnd_err", 64'(err), 64'(merr));
        if (mq.size() != 0) begin
          chk("rnd_out_instr", 64'(out_instr), 64'(mq[0].instr));
          if (mq[0].rt) begin
            chk("rnd_roundtrip", 64'(model_dec_imm(out_instr, mq[0].fmt)), 64'(mq[0].imm));
          end
        end

        r = int'($urandom_range(0, 15));
        in_fmt    = (r < 13) ? 3'(r % 5) : 3'(5 + r - 13);
        in_rd     = 5'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_funct3 = 3'($urandom);
        in_funct7 = 7'($urandom);
        case ($urandom_range(0, 9))
          0, 1:    in_imm = {$urandom, $urandom};
          2, 3:    in_imm = 64'(longint'(int'($urandom_range(0, 4095)) - 2048) * 2);
          default: in_imm = 64'(longint'(int'($urandom_range(0, 4095)) - 2048));
        endcase
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = (cyc % 400 < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
        err_clr   = ($urandom_range(0, 9) == 0);

        acc = in_valid && (mq.size() < 4);
        pop = (mq.size() != 0) && out_ready;
        if (pop) begin
          void'(mq.pop_front());
          maddr = maddr + 4;
        end
        if (acc && model_legal(in_fmt, in_imm)) begin
          ent_t e;
          e.instr = model_enc(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
          e.imm   = in_imm;
          e.fmt   = in_fmt;
          e.rt    = (in_fmt != 3'd0) && in_range(in_fmt, in_imm);
          mq.push_back(e);
        end
        if (acc && !model_legal(in_fmt, in_imm)) merr = 1'b1;
        else if (err_clr) merr = 1'b0;
        step();
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 in_valid  input  1  request carries a field set to encode.
REQ-004 in_ready  output  1  encoder accepts the request this cycle; equals !full.
REQ-005 in_fmt  input  3  format: 0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH; 5-7 illegal.
REQ-006 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-007 in_funct3  input  3; in_funct7  input  7  function fields.
REQ-008 in_imm  input  64  sign-extended immediate, same value the decoder returns.
REQ-009 out_valid  output  1  FIFO head holds an encoded instruction.
REQ-010 out_ready  input  1  consumer takes the head this cycle.
REQ-011 out_instr  output  32  encoded instruction at the FIFO head.
REQ-012 out_addr  output  32  byte address for out_instr.
REQ-013 count  output  3  FIFO occupancy, 0-4.
REQ-014 err  output  1  sticky error flag; err_clr  input  1  clears err.

Function
REQ-015 A request is accepted when in_valid && in_ready; fields are encoded combinationally and written into a 4-entry FIFO at that edge.
REQ-016 Opcodes: R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011.
REQ-017 R: {funct7, rs2, rs1, funct3, rd, op}.
REQ-018 I-ALU/LOAD: {imm[11:0], rs1, funct3, rd, op}.
REQ-019 STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
REQ-020 BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
REQ-021 Round trip: for in-range imm, decoding out_instr reproduces in_imm exactly.
REQ-022 Latency: accept at edge N gives out_valid=1 in cycle N+1 when the FIFO was empty; no combinational in-to-out path.
REQ-023 Pop on out_valid && out_ready; out_addr increments by 4 per pop and wraps 0xFFFFFFFC -> 0x00000000.
REQ-024 Simultaneous push and pop when count=4: no push, since in_ready=0; when count=0: pop is ignored and push proceeds.
REQ-025 Simultaneous push and pop when 0<count<4: count is unchanged and order is preserved.
REQ-026 Illegal in_fmt on accept: the entry is dropped, err is set, and in_ready still handshakes.
REQ-027 err_clr has priority below a same-cycle new error: err stays 1.
REQ-028 Pointers wrap modulo 4; FIFO order is strict FIFO.

Reset
REQ-029 On rst_n=0, asynchronously: FIFO empty, count=0, out_valid=0, in_ready=1, out_addr=0, err=0, out_instr=0.
REQ-030 Reset during operation discards all queued entries; the first post-reset instruction goes to address 0.

Configuration
REQ-031 Macro IMM_RANGE_CHECK_EN.
- When defined: an accept is dropped and err is set if the I/LOAD/STORE imm is not in [-2048, 2047], or the BRANCH imm is not in [-4096, 4094], or the BRANCH imm is odd.
- When undefined: no range check; the upper bits of imm are silently truncated per REQ-018 to REQ-020.
REQ-032 R format ignores in_imm in both builds.

Verification
REQ-033 I-ALU: rd=5, rs1=6, funct3=0, imm=-1 -> out_instr=0xFFF30293, out_addr=0.
REQ-034 STORE: rs2=3, rs1=2, funct3=3, imm=8 -> 0x00313423.
REQ-035 BRANCH: rs1=1, rs2=2, funct3=0, imm=-4 -> 0xFE208EE3.
REQ-036 Push 5 requests with out_ready=0 -> count=4, in_ready=0, 5th not accepted; then drain -> out_addr sequence 0, 4, 8, 12.
REQ-037 in_fmt=6 -> no FIFO write, err=1; err_clr -> err=0.
REQ-038 With the macro defined: I-ALU imm=4096 -> dropped, err=1. With the macro undefined: same request encodes imm field 0x000.
